// File: rtl/bcdr_drp_arbiter.sv
// DRP arbiter merging the quick-lock controller (port A) and a user/debug master
// (port B) onto one GTH DRP port, with a ready-timeout watchdog on the handshake.
module bcdr_drp_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          PRIO_A         = 1'b0,
  parameter logic [15:0] TIMEOUT_DATA   = 16'hFFFF
) (
  input  logic        drpClk,
  input  logic        resetN,
  input  logic [9:0]  aAddr,
  input  logic [15:0] aDin,
  input  logic        aEn,
  input  logic        aWe,
  output logic [15:0] aDout,
  output logic        aRdy,
  input  logic [9:0]  bAddr,
  input  logic [15:0] bDin,
  input  logic        bEn,
  input  logic        bWe,
  output logic [15:0] bDout,
  output logic        bRdy,
  output logic [9:0]  gtAddr,
  output logic [15:0] gtDin,
  output logic        gtEn,
  output logic        gtWe,
  input  logic [15:0] gtDout,
  input  logic        gtRdy,
  output logic        busy,
  output logic        timeoutErr,
  output logic        protoErr,
  output logic [7:0]  timeoutCnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [15:0] WD_INIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic        pendA, pendB;
  logic [9:0]  reqAddrA, reqAddrB;
  logic [15:0] reqDinA, reqDinB;
  logic        reqWeA, reqWeB;
  logic        grantB, lastGrantB;
  logic [15:0] wdog;
  logic        pickB;
  logic [15:0] rspData;

  always_comb begin
    pickB = pendB;
    if (pendA && pendB) pickB = PRIO_A ? 1'b0 : ~lastGrantB;
  end

  assign rspData = gtRdy ? gtDout : TIMEOUT_DATA;
  assign busy    = (state != IDLE);

  always_ff @(posedge drpClk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      pendA      <= 1'b0;
      pendB      <= 1'b0;
      reqAddrA   <= '0;
      reqAddrB   <= '0;
      reqDinA    <= '0;
      reqDinB    <= '0;
      reqWeA     <= 1'b0;
      reqWeB     <= 1'b0;
      grantB     <= 1'b0;
      lastGrantB <= 1'b1;
      wdog       <= '0;
      gtAddr     <= '0;
      gtDin      <= '0;
      gtEn       <= 1'b0;
      gtWe       <= 1'b0;
      aDout      <= '0;
      bDout      <= '0;
      aRdy       <= 1'b0;
      bRdy       <= 1'b0;
      timeoutErr <= 1'b0;
      protoErr   <= 1'b0;
      timeoutCnt <= '0;
    end else begin
      gtEn <= 1'b0;
      gtWe <= 1'b0;
      aRdy <= 1'b0;
      bRdy <= 1'b0;

      // A strobe while that port is still pending is dropped; the stored request survives.
      if (aEn) begin
        if (pendA) protoErr <= 1'b1;
        else begin
          pendA    <= 1'b1;
          reqAddrA <= aAddr;
          reqDinA  <= aDin;
          reqWeA   <= aWe;
        end
      end
      if (bEn) begin
        if (pendB) protoErr <= 1'b1;
        else begin
          pendB    <= 1'b1;
          reqAddrB <= bAddr;
          reqDinB  <= bDin;
          reqWeB   <= bWe;
        end
      end
      if (gtRdy && state != WAIT) protoErr <= 1'b1;

      case (state)
        IDLE: begin
          if (pendA || pendB) begin
            // DRP strobe is registered on entry so it is high exactly while in ISSUE.
            grantB     <= pickB;
            lastGrantB <= pickB;
            gtEn       <= 1'b1;
            gtWe       <= pickB ? reqWeB   : reqWeA;
            gtAddr     <= pickB ? reqAddrB : reqAddrA;
            gtDin      <= pickB ? reqDinB  : reqDinA;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wdog  <= WD_INIT;
          state <= WAIT;
        end
        WAIT: begin
          // Ready on the final watchdog cycle still wins over the abort.
          if (gtRdy || wdog == 16'd1) begin
            if (grantB) begin
              bDout <= rspData;
              bRdy  <= 1'b1;
              pendB <= 1'b0;
            end else begin
              aDout <= rspData;
              aRdy  <= 1'b1;
              pendA <= 1'b0;
            end
            if (!gtRdy) begin
              timeoutErr <= 1'b1;
              if (timeoutCnt != 8'hFF) timeoutCnt <= timeoutCnt + 8'd1;
            end
            state <= IDLE;
          end else begin
            wdog <= wdog - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcdr_drp_arbiter.sv
// Bench for bcdr_drp_arbiter: directed vector table plus hand-written
// arbitration, timeout, protocol-error and reset sequences.
module tb_bcdr_drp_arbiter;

  logic        drpClk = 1'b0;
  logic        resetN = 1'b0;
  logic [9:0]  aAddr = '0, bAddr = '0;
  logic [15:0] aDin = '0, bDin = '0;
  logic        aEn = 1'b0, aWe = 1'b0, bEn = 1'b0, bWe = 1'b0;
  logic [15:0] aDout, bDout;
  logic        aRdy, bRdy;
  logic [9:0]  gtAddr;
  logic [15:0] gtDin;
  logic        gtEn, gtWe;
  logic [15:0] gtDout = '0;
  logic        gtRdy;
  logic        busy, timeoutErr, protoErr;
  logic [7:0]  timeoutCnt;

  logic [15:0] aDoutP, bDoutP;
  logic        aRdyP, bRdyP;
  logic [9:0]  gtAddrP;
  logic [15:0] gtDinP;
  logic        gtEnP, gtWeP;
  logic [15:0] gtDoutP = 16'hBEEF;
  logic        gtRdyP = 1'b0, p1 = 1'b0;
  logic        busyP, timeoutErrP, protoErrP;
  logic [7:0]  timeoutCntP;

  int nChecks = 0;
  int nFail = 0;

  always #5 drpClk = ~drpClk;

  bcdr_drp_arbiter #(.TIMEOUT_CYCLES(8), .PRIO_A(1'b0), .TIMEOUT_DATA(16'hFFFF)) dut (
    .drpClk(drpClk), .resetN(resetN),
    .aAddr(aAddr), .aDin(aDin), .aEn(aEn), .aWe(aWe), .aDout(aDout), .aRdy(aRdy),
    .bAddr(bAddr), .bDin(bDin), .bEn(bEn), .bWe(bWe), .bDout(bDout), .bRdy(bRdy),
    .gtAddr(gtAddr), .gtDin(gtDin), .gtEn(gtEn), .gtWe(gtWe), .gtDout(gtDout), .gtRdy(gtRdy),
    .busy(busy), .timeoutErr(timeoutErr), .protoErr(protoErr), .timeoutCnt(timeoutCnt)
  );

  bcdr_drp_arbiter #(.TIMEOUT_CYCLES(8), .PRIO_A(1'b1), .TIMEOUT_DATA(16'hFFFF)) dutP (
    .drpClk(drpClk), .resetN(resetN),
    .aAddr(aAddr), .aDin(aDin), .aEn(aEn), .aWe(aWe), .aDout(aDoutP), .aRdy(aRdyP),
    .bAddr(bAddr), .bDin(bDin), .bEn(bEn), .bWe(bWe), .bDout(bDoutP), .bRdy(bRdyP),
    .gtAddr(gtAddrP), .gtDin(gtDinP), .gtEn(gtEnP), .gtWe(gtWeP), .gtDout(gtDoutP), .gtRdy(gtRdyP),
    .busy(busyP), .timeoutErr(timeoutErrP), .protoErr(protoErrP), .timeoutCnt(timeoutCntP)
  );

  // GTH model for the round-robin instance: ready mDelay cycles after the strobe.
  int          mDelay = 2;
  bit          mOn = 1'b1, mAuto = 1'b1;
  int          mCnt = 0;
  logic [15:0] mData = '0;
  logic        gtRdyM = 1'b0, strayRdy = 1'b0;
  assign gtRdy = gtRdyM | strayRdy;

  function automatic logic [15:0] resp(input logic [9:0] ad);
    return {ad[5:0], ad} ^ 16'hC3A5;
  endfunction

  always @(posedge drpClk) begin
    #1;
    gtRdyM = 1'b0;
    if (!resetN) mCnt = 0;
    if (mCnt > 0) begin
      mCnt--;
      if (mCnt == 0) gtRdyM = 1'b1;
    end
    if (gtEn && mOn) begin
      mCnt   = mDelay;
      gtDout = mAuto ? resp(gtAddr) : mData;
    end
  end

  // Fixed-priority instance answers two cycles after its strobe.
  always @(posedge drpClk) begin
    p1     <= gtEnP;
    gtRdyP <= p1;
  end

  logic [9:0] grantsM[$];
  logic [9:0] grantsP[$];
  always @(posedge drpClk) begin
    if (gtEn)  grantsM.push_back(gtAddr);
    if (gtEnP) grantsP.push_back(gtAddrP);
  end

  typedef struct {
    bit          isB;
    bit          we;
    logic [9:0]  addr;
    logic [15:0] din;
    int          delay;
    logic [15:0] rdata;
    logic [15:0] expDout;
    int          expRdyLat;
    logic [7:0]  expCnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge drpClk);
    #1;
  endtask

  function automatic logic sigOf(input int w);
    case (w)
      0:       return gtEn;
      1:       return aRdy;
      default: return bRdy;
    endcase
  endfunction

  task automatic waitFor(input int w, input int limit, output int n);
    n = 0;
    while (!sigOf(w) && n < limit) begin
      step();
      n++;
    end
    if (!sigOf(w)) begin
      nChecks++;
      nFail++;
      $display("FAIL wait%0d: no event within %0d cycles", w, limit);
    end
  endtask

  task automatic req(input bit isB, input bit we, input logic [9:0] ad, input logic [15:0] di);
    if (isB) begin
      bEn = 1'b1; bWe = we; bAddr = ad; bDin = di;
    end else begin
      aEn = 1'b1; aWe = we; aAddr = ad; aDin = di;
    end
  endtask

  task automatic relEn();
    aEn = 1'b0;
    bEn = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "Dout"}, {aDout, bDout}, 32'h0);
    check({tag, "Gt"}, {4'h0, gtAddr, gtDin, gtEn, gtWe}, 32'h0);
    check({tag, "Flags"}, {aRdy, bRdy, busy, timeoutErr, protoErr, timeoutCnt}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL globalTimeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, aSeen, eSeen;
    bit reA, reB;

    vecs[0] = '{1'b0, 1'b0, 10'h063, 16'h0000, 3, 16'h1234, 16'h1234, 4, 8'd0};
    vecs[1] = '{1'b1, 1'b1, 10'h0A5, 16'h5A5A, 1, 16'h0F0F, 16'h0F0F, 2, 8'd0};
    vecs[2] = '{1'b0, 1'b1, 10'h3FF, 16'h8001, 8, 16'h00AA, 16'h00AA, 9, 8'd0};
    vecs[3] = '{1'b0, 1'b0, 10'h100, 16'h0000, 0, 16'h0000, 16'hFFFF, 9, 8'd1};
    vecs[4] = '{1'b1, 1'b0, 10'h201, 16'h0000, 2, 16'h7E57, 16'h7E57, 3, 8'd1};

    step();
    step();
    checkAllZero("reset");
    resetN = 1'b1;
    step();

    // Collision from reset: A wins the first tie, B follows back-to-back.
    grantsM.delete();
    grantsP.delete();
    req(1'b0, 1'b1, 10'h0A4, 16'h00FF);
    req(1'b1, 1'b0, 10'h0A5, 16'h0000);
    step();
    relEn();
    waitFor(0, 20, n);
    check("colFirstAddr", gtAddr, 10'h0A4);
    check("colFirstWe", gtWe, 1'b1);
    check("colFirstDin", gtDin, 16'h00FF);
    waitFor(1, 30, n);
    check("colADout", aDout, resp(10'h0A4));
    check("colBRdyIdle", bRdy, 1'b0);
    waitFor(0, 20, n);
    check("b2bGapFromRdy", n + 1, 2);
    check("colSecondAddr", gtAddr, 10'h0A5);
    waitFor(2, 30, n);
    check("colBDout", bDout, resp(10'h0A5));
    check("colProto", protoErr, 1'b0);
    step();
    step();
    check("colGrantsP", grantsP.size(), 2);
    if (grantsP.size() == 2) check("colOrderP", {grantsP[0], grantsP[1]}, {10'h0A4, 10'h0A5});

    // Fairness: each port re-requests on its own completion while the other is pending.
    grantsM.delete();
    req(1'b0, 1'b0, 10'h0C1, 16'h0000);
    req(1'b1, 1'b0, 10'h0C2, 16'h0000);
    step();
    relEn();
    reA = 1'b1;
    reB = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (aRdy && reA) begin
        req(1'b0, 1'b0, 10'h0C3, 16'h0000);
        reA = 1'b0;
      end
      if (bRdy && reB) begin
        req(1'b1, 1'b0, 10'h0C4, 16'h0000);
        reB = 1'b0;
      end
      step();
      relEn();
    end
    check("fairCount", grantsM.size(), 4);
    if (grantsM.size() == 4)
      check("fairOrder", {2'b00, grantsM[0], grantsM[1], grantsM[2]}, {2'b00, 10'h0C1, 10'h0C2, 10'h0C3});
    if (grantsM.size() == 4) check("fairLast", grantsM[3], 10'h0C4);

    // Priority vs round-robin once A was the last grant.
    req(1'b0, 1'b0, 10'h111, 16'h0000);
    step();
    relEn();
    waitFor(1, 30, n);
    step();
    step();
    grantsM.delete();
    grantsP.delete();
    req(1'b0, 1'b0, 10'h111, 16'h0000);
    req(1'b1, 1'b0, 10'h222, 16'h0000);
    step();
    relEn();
    for (int t = 0; t < 30; t++) step();
    check("rrCount", grantsM.size(), 2);
    if (grantsM.size() == 2) check("rrOrder", {grantsM[0], grantsM[1]}, {10'h222, 10'h111});
    check("prioCount", grantsP.size(), 2);
    if (grantsP.size() == 2) check("prioOrder", {grantsP[0], grantsP[1]}, {10'h111, 10'h222});

    // Single-port transactions: latency, data, watchdog boundary and abort.
    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v = vecs[i];
      mOn    = (v.delay != 0);
      mDelay = v.delay;
      mAuto  = 1'b0;
      mData  = v.rdata;
      req(v.isB, v.we, v.addr, v.din);
      step();
      relEn();
      waitFor(0, 20, n);
      check($sformatf("v%0d issueLat", i), n + 1, 2);
      check($sformatf("v%0d gtAddr", i), gtAddr, v.addr);
      check($sformatf("v%0d gtWe", i), gtWe, v.we);
      check($sformatf("v%0d gtDin", i), gtDin, v.din);
      waitFor(v.isB ? 2 : 1, 30, n);
      check($sformatf("v%0d rdyLat", i), n, v.expRdyLat);
      check($sformatf("v%0d dout", i), v.isB ? bDout : aDout, v.expDout);
      check($sformatf("v%0d otherRdy", i), v.isB ? aRdy : bRdy, 1'b0);
      check($sformatf("v%0d toErr", i), timeoutErr, v.expCnt != 8'd0);
      check($sformatf("v%0d toCnt", i), timeoutCnt, v.expCnt);
      step();
      check($sformatf("v%0d rdyPulse", i), v.isB ? bRdy : aRdy, 1'b0);
      check($sformatf("v%0d doutHold", i), v.isB ? bDout : aDout, v.expDout);
    end
    mAuto = 1'b1;

    // Watchdog abort counter saturates.
    mOn = 1'b0;
    for (int k = 0; k < 255; k++) begin
      req(1'b0, 1'b0, 10'h155, 16'h0000);
      step();
      relEn();
      waitFor(1, 20, n);
      step();
    end
    check("toCntSat", timeoutCnt, 8'hFF);

    // Strobe while pending is dropped; the first request completes untouched.
    mOn = 1'b1;
    mDelay = 2;
    check("protoBefore", protoErr, 1'b0);
    req(1'b0, 1'b0, 10'h0AA, 16'h0000);
    step();
    req(1'b0, 1'b1, 10'h155, 16'h1111);
    step();
    relEn();
    check("protoDrop", protoErr, 1'b1);
    waitFor(0, 20, n);
    check("dropAddr", gtAddr, 10'h0AA);
    check("dropWe", gtWe, 1'b0);
    waitFor(1, 30, n);
    check("dropDout", aDout, resp(10'h0AA));
    step();
    step();
    step();
    check("dropNoRetry", busy, 1'b0);

    // Reset in WAIT abandons the transaction and clears sticky state.
    mOn = 1'b0;
    req(1'b0, 1'b0, 10'h050, 16'h0000);
    step();
    relEn();
    waitFor(0, 20, n);
    step();
    step();
    resetN = 1'b0;
    #1;
    checkAllZero("midRst");
    step();
    step();
    resetN = 1'b1;
    aSeen = 0;
    eSeen = 0;
    for (int t = 0; t < 14; t++) begin
      step();
      if (aRdy) aSeen++;
      if (gtEn) eSeen++;
    end
    check("rstNoRdy", aSeen, 0);
    check("rstNoEn", eSeen, 0);
    mOn = 1'b1;
    req(1'b0, 1'b0, 10'h060, 16'h0000);
    step();
    relEn();
    waitFor(0, 20, n);
    check("postRstLat", n + 1, 2);
    waitFor(1, 30, n);
    check("postRstDout", aDout, resp(10'h060));

    // Stray ready in IDLE flags a protocol error and produces no completion.
    step();
    step();
    check("strayBefore", protoErr, 1'b0);
    strayRdy = 1'b1;
    step();
    strayRdy = 1'b0;
    check("strayProto", protoErr, 1'b1);
    check("strayRdyNow", {aRdy, bRdy}, 2'b00);
    step();
    check("strayRdyNext", {aRdy, bRdy}, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/bcdr_drp_arbiter.md
Name: bcdr_drp_arbiter

Overview:
Downstream DRP arbiter between the burst-mode CDR quick-lock controller and the GTH channel DRP port.
- Merges two single-outstanding DRP masters onto one DRP slave: port A is the quick-lock controller; port B is the user/debug or other sequencer.
- Latches single-cycle enable pulses and arbitrates between them.
- Guards the transceiver handshake with a ready-timeout watchdog, so a stalled GTH never hangs quick-lock.

Parameters:
TIMEOUT_CYCLES, 255, cycles waited in WAIT for gtRdy before abort (1..65535).
PRIO_A, 0, 1 = port A fixed priority; 0 = round-robin.
TIMEOUT_DATA, 16'hFFFF, read data returned to the master on timeout.

Ports:
drpClk  in  1  DRP clock; all logic on its rising edge.
resetN  in  1  asynchronous active-low reset.
aAddr  in  10  port A address, sampled when aEn=1.
aDin  in  16  port A write data.
aEn  in  1  port A single-cycle request strobe.
aWe  in  1  port A write enable, qualified by aEn.
aDout  out  16  port A read data, valid while aRdy=1.
aRdy  out  1  port A completion pulse.
bAddr, bDin, bEn, bWe, bDout, bRdy: same widths and meanings for port B.
gtAddr  out  10  GTH DRP address.
gtDin  out  16  GTH DRP write data.
gtEn  out  1  GTH DRP enable.
gtWe  out  1  GTH DRP write enable.
gtDout  in  16  GTH DRP read data.
gtRdy  in  1  GTH DRP ready.
busy  out  1  high in ISSUE or WAIT.
timeoutErr  out  1  sticky, set on any watchdog abort.
protoErr  out  1  sticky, set on request while pending, or on stray gtRdy.
timeoutCnt  out  8  saturating count of aborts.

Behaviour:
Reset (asynchronous, resetN=0):
- All outputs 0; gtAddr/gtDin/aDout/bDout = 0.
- Pending flags cleared; state = IDLE; lastGrant = B, so A wins the first tie.

Request capture, per port:
- xEn=1 with pendX=0: register addr/din/we, set pendX next edge.
- xEn=1 with pendX=1: request dropped, protoErr set, stored request unchanged.

FSM:
- IDLE:
  - No pending request: stay.
  - Both pending: PRIO_A=1 grants A; otherwise grant the port opposite lastGrant.
  - Record grant; go ISSUE.
- ISSUE:
  - For exactly one cycle: gtEn=1, gtWe, gtAddr, gtDin driven from the granted pending registers.
  - Load watchdog = TIMEOUT_CYCLES; go WAIT.
- WAIT:
  - gtEn=0; gtAddr/gtDin hold.
  - gtRdy=1: next cycle xDout = gtDout (write transactions also return gtDout) and xRdy=1 for one cycle; clear pendX; state → IDLE.
  - Else watchdog decrements. On reaching 0 with no gtRdy: xDout = TIMEOUT_DATA, xRdy pulse, clear pendX, set timeoutErr, timeoutCnt += 1 saturating at 255; state → IDLE.
  - gtRdy in the same cycle the watchdog hits 0 counts as success, not timeout.

Latency:
- xEn sampled at edge N with arbiter idle → gtEn high in cycle N+2.
- gtRdy sampled at edge M → xRdy high in cycle M+1.
- Back-to-back: a second grant gtEn no earlier than M+2.

Boundary conditions:
- gtRdy outside WAIT: ignored for data, protoErr set.
- The non-granted port's pending request is held indefinitely, no loss.
- Round-robin: after serving A with B pending, B is served next even if A re-requests.
- xRdy output registers are the only drivers of xDout; xDout holds its value after the pulse.
- New xEn in the cycle xRdy is high is legal: pendX was cleared at that edge.
- resetN asserted mid-WAIT: transaction abandoned, no xRdy, gtEn stays 0, sticky flags cleared.

Test Plan:
- Single read A: aEn, aAddr=10'h063, aWe=0 at edge 0; model returns gtDout=16'h1234 with gtRdy 3 cycles after gtEn → gtEn in cycle 2 with gtAddr=10'h063; aRdy one cycle with aDout=16'h1234; bRdy never.
- Collision, PRIO_A=0: aEn and bEn in the same cycle (A write 10'h0A4/16'h00FF, B read 10'h0A5) → A issued first, then B; no protoErr; second gtEn ≥2 cycles after aRdy.
- Fairness: A requests continuously on each aRdy while B is pending → grants alternate A,B,A,B; with PRIO_A=1 → B waits until A stops.
- Timeout: TIMEOUT_CYCLES=8, model never asserts gtRdy → aRdy pulse 9 cycles after gtEn with aDout=16'hFFFF; timeoutErr=1; timeoutCnt=1; next request proceeds normally.
- Protocol errors: second aEn while pendA=1 → protoErr=1, first request completes unchanged; stray gtRdy in IDLE → protoErr=1, no xRdy.
- Reset mid-WAIT: resetN low 2 cycles during WAIT → no aRdy; all outputs 0; timeoutCnt=0; new request afterwards completes with 2-cycle gtEn latency.
